// File: rtl/fixed_p_pkg.sv
// Shared definitions for the unsigned fixed-point sequential divider.
// Optional feature macro: FIXED_P_DIV_ROUND_EN (adds one guard step and
// rounds the quotient half-up instead of truncating).
package fixed_p_pkg;

   // Controller states of the divider
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

`ifdef FIXED_P_DIV_ROUND_EN
   localparam int DIV_ROUND_STEPS = 1;
`else
   localparam int DIV_ROUND_STEPS = 0;
`endif

   // Number of restoring steps for one divide: one per quotient bit of the
   // (width + fract_width)-bit quotient, plus the guard step when rounding.
   function automatic int div_steps(input int width, input int fract_width);
      return width + fract_width + DIV_ROUND_STEPS;
   endfunction

   // Step counter width; large enough for every step count including the
   // optional guard step.
   function automatic int div_cnt_width(input int width, input int fract_width);
      return $clog2(width + fract_width + 2);
   endfunction

   // Counter width for the default 32-bit, 24-fraction-bit configuration
   localparam int DIV_CNT_W = div_cnt_width(32, 24);

endpackage

// File: rtl/fixed_p_div_step.sv
// One combinational restoring-division step: shift the incoming dividend bit
// into the partial remainder and subtract the divisor when it fits.
module fixed_p_div_step #(
   parameter int width = 32
) (
   input  logic [width-1:0] partial,
   input  logic             in_bit,
   input  logic [width-1:0] divisor,
   output logic [width-1:0] next_partial,
   output logic             q_bit
);

   // The shifted partial can exceed width bits before the subtraction, so the
   // trial value carries one extra bit; the result always fits back in width.
   logic [width:0] trial;
   logic [width:0] diff;

   assign trial = {partial, in_bit};
   assign diff  = trial - {1'b0, divisor};

   // Restore (keep the trial) when the divisor does not fit
   always_comb begin
      q_bit        = 1'b0;
      next_partial = trial[width-1:0];
      if (trial >= {1'b0, divisor}) begin
         q_bit        = 1'b1;
         next_partial = diff[width-1:0];
      end
   end

endmodule

// File: rtl/fixed_p_std_div_pipe.sv
// Sequential unsigned fixed-point divider: out_quotient = left / right in the
// width/int_width/fract_width format, one quotient bit per cycle, go/done
// handshake, with remainder, overflow saturation and divide-by-zero flag.
// Optional feature macro: FIXED_P_DIV_ROUND_EN (round half-up via guard step).
module fixed_p_std_div_pipe
   import fixed_p_pkg::*;
#(
   parameter int width       = 32,
   parameter int int_width   = 8,
   parameter int fract_width = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [width-1:0] left,
   input  logic [width-1:0] right,
   output logic [width-1:0] out_quotient,
   output logic [width-1:0] out_remainder,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             done
);

   localparam int N     = width + fract_width;
   localparam int STEPS = div_steps(width, fract_width);
   localparam int CW    = div_cnt_width(width, fract_width);
   localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

   if (int_width + fract_width != width) begin : g_cfg_check
      $error("fixed_p_std_div_pipe: int_width + fract_width must equal width");
   end

   div_state_t       state;
   logic [CW-1:0]    cnt;
   logic [N-1:0]     dvd_reg;    // dividend (left << fract_width), MSB first
   logic [N-1:0]     quot_reg;   // quotient shift register
   logic [width-1:0] part_reg;   // partial remainder
   logic [width-1:0] div_reg;    // latched divisor

   logic [width-1:0] step_part;
   logic             step_q;

   fixed_p_div_step #(.width(width)) u_step (
      .partial      (part_reg),
      .in_bit       (dvd_reg[N-1]),
      .divisor      (div_reg),
      .next_partial (step_part),
      .q_bit        (step_q)
   );

   // Final result as seen during the last step of BUSY
   logic [N-1:0]     trunc_q;
   logic [width-1:0] fin_rem;
   logic             guard;
   logic [width:0]   rounded;
   logic             fin_ov;

`ifdef FIXED_P_DIV_ROUND_EN
   // The last step only produces the guard bit; the truncated quotient and its
   // remainder are already complete in the registers.
   assign trunc_q = quot_reg;
   assign fin_rem = part_reg;
   assign guard   = step_q;
`else
   // The last step produces the quotient LSB and the final remainder.
   assign trunc_q = {quot_reg[N-2:0], step_q};
   assign fin_rem = step_part;
   assign guard   = 1'b0;
`endif

   assign rounded = {1'b0, trunc_q[width-1:0]} + {{width{1'b0}}, guard};
   // Quotient does not fit when bits above width are set or rounding carries
   // out. A bit already shifted past position N-1 would mean the same thing,
   // so it is folded in as well.
   assign fin_ov  = (|trunc_q[N-1:width]) | rounded[width] | quot_reg[N-1];

   // Controller and datapath: operand latch, restoring steps, step counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         dvd_reg  <= '0;
         quot_reg <= '0;
         part_reg <= '0;
         div_reg  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  div_reg  <= right;
                  dvd_reg  <= {left, {fract_width{1'b0}}};
                  quot_reg <= '0;
                  part_reg <= '0;
                  cnt      <= '0;
                  state    <= (right == '0) ? DONE : BUSY;
               end
            end
            BUSY: begin
               part_reg <= step_part;
               quot_reg <= {quot_reg[N-2:0], step_q};
               dvd_reg  <= {dvd_reg[N-2:0], 1'b0};
               cnt      <= cnt + CW'(1);
               if (cnt == LAST_STEP) begin
                  state <= DONE;
               end
            end
            DONE: begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result registers: written only on entry to DONE, held otherwise
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_quotient  <= '0;
         out_remainder <= '0;
         overflow      <= 1'b0;
         div_by_zero   <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && go && right == '0) begin
            out_quotient  <= '1;
            out_remainder <= left;
            overflow      <= 1'b0;
            div_by_zero   <= 1'b1;
            done          <= 1'b1;
         end else if (state == BUSY && cnt == LAST_STEP) begin
            out_quotient  <= fin_ov ? {width{1'b1}} : rounded[width-1:0];
            out_remainder <= fin_rem;
            overflow      <= fin_ov;
            div_by_zero   <= 1'b0;
            done          <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fixed_p_std_div_pipe.sv
// Self-checking bench for fixed_p_std_div_pipe (width 8, int 4, fract 4).
// Honours FIXED_P_DIV_ROUND_EN for expected latency and rounding.
module tb_fixed_p_std_div_pipe;

   localparam int W  = 8;
   localparam int FW = 4;
   localparam int N  = W + FW;
`ifdef FIXED_P_DIV_ROUND_EN
   localparam int RND = 1;
`else
   localparam int RND = 0;
`endif
   localparam int STEPS = N + RND;
   localparam logic [7:0] Q_2_DIV_3 = (RND == 1) ? 8'h0B : 8'h0A;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       go = 1'b0;
   logic [7:0] left = '0;
   logic [7:0] right = '0;
   logic [7:0] out_quotient;
   logic [7:0] out_remainder;
   logic       overflow;
   logic       div_by_zero;
   logic       done;

   always #5 clk = ~clk;

   fixed_p_std_div_pipe #(.width(8), .int_width(4), .fract_width(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .go            (go),
      .left          (left),
      .right         (right),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .overflow      (overflow),
      .div_by_zero   (div_by_zero),
      .done          (done)
   );

   typedef struct {
      int         due;
      logic [7:0] q;
      logic [7:0] r;
      logic       ov;
      logic       dz;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   fails = 0;
   int   cyc = 0;
   int   pushed = 0;
   int   done_cnt = 0;
   bit   mon_en = 1'b0;
   logic [7:0] hq = '0, hr = '0;
   logic hov = 1'b0, hdz = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: quotient of (left * 2^FW) / right by plain integer arithmetic;
   // due is the edge count after which done must be visible.
   function automatic exp_t model(input logic [7:0] l, input logic [7:0] r, input int accept);
      exp_t   x;
      longint num, qq, rr;
      if (r == 0) begin
         x.due = accept;
         x.q = 8'hFF; x.r = l; x.ov = 1'b0; x.dz = 1'b1;
      end else begin
         x.due = accept + STEPS;
         num = longint'(l) * (longint'(1) << FW);
         qq  = num / longint'(r);
         rr  = num % longint'(r);
         if (RND == 1 && 2 * rr >= longint'(r)) qq++;
         x.ov = (qq > 255);
         x.q  = x.ov ? 8'hFF : 8'(qq);
         x.r  = 8'(rr);
         x.dz = 1'b0;
      end
      return x;
   endfunction

   // Cycle-by-cycle compare against the model's expected done schedule
   always @(negedge clk) begin
      if (mon_en) begin
         if (done === 1'b1) done_cnt++;
         if (expq.size() > 0 && expq[0].due == cyc) begin
            check("done_pulse", 32'(done), 32'd1);
            check("quotient", 32'(out_quotient), 32'(expq[0].q));
            check("remainder", 32'(out_remainder), 32'(expq[0].r));
            check("overflow", 32'(overflow), 32'(expq[0].ov));
            check("div_by_zero", 32'(div_by_zero), 32'(expq[0].dz));
            hq = expq[0].q; hr = expq[0].r; hov = expq[0].ov; hdz = expq[0].dz;
            void'(expq.pop_front());
         end else begin
            check("done_low", 32'(done), 32'd0);
            check("hold_quotient", 32'(out_quotient), 32'(hq));
            check("hold_remainder", 32'(out_remainder), 32'(hr));
            check("hold_overflow", 32'(overflow), 32'(hov));
            check("hold_div_by_zero", 32'(div_by_zero), 32'(hdz));
         end
      end
   end

   // Issue one operation from IDLE (called at a negedge) and wait until the
   // DUT is back in IDLE; operands are scrambled while it is busy.
   task automatic do_op(input logic [7:0] l, input logic [7:0] r);
      exp_t x;
      go = 1'b1; left = l; right = r;
      x = model(l, r, cyc + 1);
      expq.push_back(x);
      pushed++;
      @(negedge clk);
      go = 1'b0; left = 8'($urandom); right = 8'($urandom);
      while (cyc < x.due + 1) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t x;
      int   accept;
      logic [7:0] l, r;

      // Pin the model itself with hand-computed values
      x = model(8'h30, 8'h20, 0);
      check("model_3_div_2_q", 32'(x.q), 32'h18);
      x = model(8'h20, 8'h30, 0);
      check("model_2_div_3_q", 32'(x.q), 32'(Q_2_DIV_3));
      check("model_2_div_3_r", 32'(x.r), 32'h20);
      x = model(8'hF0, 8'h08, 0);
      check("model_ovf", 32'(x.ov), 32'd1);

      // Asynchronous reset at start-up
      #2 reset = 1'b0;
      @(negedge clk);
      check("rst_quotient", 32'(out_quotient), 32'd0);
      check("rst_remainder", 32'(out_remainder), 32'd0);
      check("rst_flags", {29'd0, overflow, div_by_zero, done}, 32'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      // Directed cases with literal expectations
      do_op(8'h30, 8'h20);
      check("lit_3_div_2_q", 32'(out_quotient), 32'h18);
      check("lit_3_div_2_r", 32'(out_remainder), 32'h00);
      do_op(8'h20, 8'h30);
      check("lit_2_div_3_q", 32'(out_quotient), 32'(Q_2_DIV_3));
      check("lit_2_div_3_r", 32'(out_remainder), 32'h20);
      do_op(8'hF0, 8'h08);
      check("lit_ovf_q", 32'(out_quotient), 32'hFF);
      check("lit_ovf_flag", 32'(overflow), 32'd1);
      check("lit_ovf_r", 32'(out_remainder), 32'h00);
      do_op(8'h40, 8'h00);
      check("lit_dz_q", 32'(out_quotient), 32'hFF);
      check("lit_dz_r", 32'(out_remainder), 32'h40);
      check("lit_dz_flag", 32'(div_by_zero), 32'd1);

      // Reset in the middle of a busy operation aborts it
      go = 1'b1; left = 8'h30; right = 8'h20;
      accept = cyc + 1;
      @(negedge clk);
      go = 1'b0;
      while (cyc < accept + 4) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_quotient", 32'(out_quotient), 32'd0);
      check("midrst_remainder", 32'(out_remainder), 32'd0);
      check("midrst_flags", {29'd0, overflow, div_by_zero, done}, 32'd0);
      hq = '0; hr = '0; hov = 1'b0; hdz = 1'b0;
      expq.delete();
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      do_op(8'h30, 8'h20);
      check("post_rst_q", 32'(out_quotient), 32'h18);

      // go held high for three back-to-back operations
      go = 1'b1;
      for (int k = 0; k < 3; k++) begin
         l = 8'($urandom);
         r = 8'($urandom_range(1, 255));
         left = l; right = r;
         x = model(l, r, cyc + 1);
         expq.push_back(x);
         pushed++;
         @(negedge clk);
         left = 8'($urandom); right = 8'($urandom);
         if (k == 2) go = 1'b0;
         while (cyc < x.due + 1) @(negedge clk);
      end

      // Randomized operations, including small divisors and zero
      for (int k = 0; k < 40; k++) begin
         l = 8'($urandom);
         case ($urandom_range(0, 3))
            0: r = 8'($urandom_range(0, 3));
            1: r = 8'($urandom_range(1, 16));
            default: r = 8'($urandom);
         endcase
         do_op(l, r);
      end

      repeat (3) @(negedge clk);
      check("done_count", 32'(done_cnt), 32'(pushed));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
